cart_dl_ctrl: RTL and testbench

CART_DL_CTRL -- requirements
Module: cart_dl_ctrl

---
 rtl/atari_dl_pkg.sv | 17 +
 rtl/dl_fifo.sv | 50 +++++
 rtl/cart_dl_ctrl.sv | 157 +++++++++++++++
 tb/tb_cart_dl_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atari_dl_pkg.sv
// Shared types and constants for the cartridge/BIOS download path.
// Imported by the FIFO and the download controller.
package atari_dl_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } dl_state_e;

  localparam logic [7:0]  IDX_NOFILE    = 8'd99;
  localparam logic [25:0] BIOS_BASE_DEF = 26'h2704000;
  localparam int          ENTRY_W       = 34;

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO of {addr, byte} download entries.
// Pushes into a full FIFO are dropped; pops of an empty one are ignored.
module dl_fifo
  import atari_dl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/cart_dl_ctrl.sv
// HPS download controller: buffers ioctl bytes into a FIFO and issues
// single-byte DMA requests; index 0 also feeds the on-chip BIOS RAM.
module cart_dl_ctrl
  import atari_dl_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          TIMEOUT     = 4096,
  parameter logic [25:0] BIOS_BASE   = BIOS_BASE_DEF,
  parameter bit          MIRROR_BIOS = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        sdram_ready,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic        dma_req,
  output logic [25:0] dma_addr,
  output logic [7:0]  dma_data,
  input  logic        dma_ready,
  output logic        bios_we,
  output logic [10:0] bios_addr,
  output logic [7:0]  bios_data,
  output logic        file_download,
  output logic        dl_done,
  output logic        dl_error
);

  localparam int AW = $clog2(DEPTH);

  dl_state_e state_q, state_d;

  logic [7:0]  idx_q;
  logic        wait_q, wait_d;
  logic        err_q;
  logic        req_q;
  logic [25:0] daddr_q;
  logic [7:0]  ddata_q;
  logic        bwe_q;
  logic [10:0] baddr_q;
  logic [7:0]  bdata_q;
  logic [11:0] to_q;

  logic                 push, pop, load;
  logic                 wr_run, is_bios, start;
  logic                 timeout_hit, overflow;
  logic [ENTRY_W-1:0]   wdata, rdata;
  logic [AW:0]          count, cnt_nxt;
  logic                 full, empty;
  logic                 unused;

  assign unused = ioctl_addr[26];

  assign wr_run  = (state_q == S_RUN) && ioctl_wr;
  assign is_bios = (idx_q == 8'd0);
  assign push    = wr_run && (!is_bios || MIRROR_BIOS);
  assign wdata   = is_bios
                 ? {BIOS_BASE | {15'd0, ioctl_addr[10:0]}, ioctl_dout}
                 : {ioctl_addr[25:0], ioctl_dout};

  assign timeout_hit = req_q && (to_q == 12'(TIMEOUT-1));
  assign pop         = req_q && (dma_ready || timeout_hit);
  assign load        = !req_q && !empty;
  assign overflow    = push && full;

  assign cnt_nxt = count + (AW+1)'(push && !full)
                 - (AW+1)'(pop && !empty);

  dl_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (sdram_ready) state_d = S_IDLE;
      S_IDLE:  if (ioctl_download && ioctl_index != IDX_NOFILE)
                 state_d = S_RUN;
      S_RUN:   if (!ioctl_download) state_d = S_DRAIN;
      S_DRAIN: if (empty && !req_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  assign start = (state_q == S_IDLE) && (state_d == S_RUN);

  // Wait is computed from next state/count so the registered value
  // tracks the current occupancy without a cycle of lag.
  assign wait_d = (state_d == S_INIT)
               || (cnt_nxt >= (AW+1)'(DEPTH-1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      wait_q  <= 1'b1;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
      bwe_q   <= 1'b0;
      baddr_q <= '0;
      bdata_q <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (start) idx_q <= ioctl_index;

      if (start)                        err_q <= 1'b0;
      else if (overflow || timeout_hit) err_q <= 1'b1;

      if (pop) begin
        req_q <= 1'b0;
      end else if (load) begin
        req_q   <= 1'b1;
        daddr_q <= rdata[33:8];
        ddata_q <= rdata[7:0];
      end

      to_q <= (req_q && !pop) ? to_q + 12'd1 : 12'd0;

      bwe_q <= wr_run && is_bios;
      if (wr_run && is_bios) begin
        baddr_q <= ioctl_addr[10:0];
        bdata_q <= ioctl_dout;
      end
    end
  end

  assign ioctl_wait    = wait_q;
  assign dma_req       = req_q;
  assign dma_addr      = daddr_q;
  assign dma_data      = ddata_q;
  assign bios_we       = bwe_q;
  assign bios_addr     = baddr_q;
  assign bios_data     = bdata_q;
  assign dl_error      = err_q;
  assign file_download = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign dl_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_cart_dl_ctrl.sv
// Directed bench for cart_dl_ctrl: reset, file and BIOS downloads,
// back-pressure/overflow, DMA timeout and reset during a request.
module tb_cart_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        sdram_ready;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic        dma_req;
  logic [25:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_ready;
  logic        bios_we;
  logic [10:0] bios_addr;
  logic [7:0]  bios_data;
  logic        file_download;
  logic        dl_done;
  logic        dl_error;

  int vecs = 0;
  int errs = 0;

  always #5 clk_sys = ~clk_sys;

  cart_dl_ctrl dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .sdram_ready    (sdram_ready),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .dma_req        (dma_req),
    .dma_addr       (dma_addr),
    .dma_data       (dma_data),
    .dma_ready      (dma_ready),
    .bios_we        (bios_we),
    .bios_addr      (bios_addr),
    .bios_data      (bios_data),
    .file_download  (file_download),
    .dl_done        (dl_done),
    .dl_error       (dl_error)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (dma_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Returns one cycle after the dl_done pulse, with the FSM back in IDLE.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (dl_done) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sdram_ready = 1'b0;
    repeat (3) step();
    vecs++;
    if (ioctl_wait !== 1'b1) begin
      $display("FAIL rst_wait: got %0b want 1", ioctl_wait); errs++;
    end
    vecs++;
    if ({dma_req, bios_we, dl_done, dl_error, file_download} !== 5'b0) begin
      $display("FAIL rst_outs: got %05b want 00000",
               {dma_req, bios_we, dl_done, dl_error, file_download});
      errs++;
    end
    vecs++;
    if (dma_addr !== 26'd0 || bios_addr !== 11'd0) begin
      $display("FAIL rst_addr: got %0h/%0h want 0/0", dma_addr, bios_addr);
      errs++;
    end
    reset = 1'b0;
    step();
    vecs++;
    if (ioctl_wait !== 1'b1) begin
      $display("FAIL init_wait: got %0b want 1", ioctl_wait); errs++;
    end
    sdram_ready = 1'b1;
    step();
    vecs++;
    if (ioctl_wait !== 1'b0) begin
      $display("FAIL idle_wait: got %0b want 0", ioctl_wait); errs++;
    end
    ioctl_index = 8'd99;
    ioctl_download = 1'b1;
    step();
    step();
    vecs++;
    if (file_download !== 1'b0) begin
      $display("FAIL idx99: got %0b want 0", file_download); errs++;
    end
    ioctl_download = 1'b0;
    step();
  endtask

  task automatic test_file_dl();
    bit ok;
    bit extra;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    step();
    vecs++;
    if (file_download !== 1'b1) begin
      $display("FAIL f_run: got %0b want 1", file_download); errs++;
    end
    fork
      begin : writer
        for (int i = 0; i < 8; i++) begin
          int g = 0;
          while (ioctl_wait && g < 100) begin
            step();
            g++;
          end
          ioctl_wr = 1'b1;
          ioctl_addr = 27'(i);
          ioctl_dout = 8'h10 + 8'(i);
          step();
          ioctl_wr = 1'b0;
        end
        ioctl_download = 1'b0;
      end
      begin : responder
        for (int r = 0; r < 8; r++) begin
          bit got;
          wait_req(200, got);
          vecs++;
          if (!got) begin
            $display("FAIL f_req%0d: got no request want request", r);
            errs++;
            break;
          end
          vecs++;
          if (dma_addr !== 26'(r) || dma_data !== 8'h10 + 8'(r)) begin
            $display("FAIL f_data%0d: got %0h/%0h want %0h/%0h",
                     r, dma_addr, dma_data, r, 8'h10 + 8'(r));
            errs++;
          end
          step();
          dma_ready = 1'b1;
          step();
          dma_ready = 1'b0;
        end
      end
    join
    wait_done(ok);
    vecs++;
    if (!ok) begin
      $display("FAIL f_done: got no pulse want pulse"); errs++;
    end
    extra = 1'b0;
    repeat (4) begin
      step();
      if (dl_done) extra = 1'b1;
    end
    vecs++;
    if (extra !== 1'b0) begin
      $display("FAIL f_done_once: got %0b want 0", extra); errs++;
    end
    vecs++;
    if (dl_error !== 1'b0 || file_download !== 1'b0) begin
      $display("FAIL f_flags: got %0b/%0b want 0/0", dl_error, file_download);
      errs++;
    end
  endtask

  task automatic test_bios();
    bit ok;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    step();
    ioctl_wr = 1'b1;
    ioctl_addr = 27'h7FF;
    ioctl_dout = 8'hA5;
    step();
    ioctl_wr = 1'b0;
    vecs++;
    if (bios_we !== 1'b1 || bios_addr !== 11'h7FF || bios_data !== 8'hA5) begin
      $display("FAIL b_we: got %0b/%0h/%0h want 1/7ff/a5",
               bios_we, bios_addr, bios_data);
      errs++;
    end
    step();
    vecs++;
    if (bios_we !== 1'b0) begin
      $display("FAIL b_pulse: got %0b want 0", bios_we); errs++;
    end
    vecs++;
    if (dma_req !== 1'b1 || dma_addr !== 26'h27047FF || dma_data !== 8'hA5) begin
      $display("FAIL b_mirror: got %0b/%0h/%0h want 1/27047ff/a5",
               dma_req, dma_addr, dma_data);
      errs++;
    end
    dma_ready = 1'b1;
    step();
    dma_ready = 1'b0;
    ioctl_download = 1'b0;
    wait_done(ok);
    vecs++;
    if (!ok) begin
      $display("FAIL b_done: got no pulse want pulse"); errs++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    dma_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 27'(32'h100 + i);
      ioctl_dout = 8'h40 + 8'(i);
      step();
      if (i == 1) begin
        vecs++;
        if (ioctl_wait !== 1'b0) begin
          $display("FAIL o_wait2: got %0b want 0", ioctl_wait); errs++;
        end
      end
      if (i == 2) begin
        vecs++;
        if (ioctl_wait !== 1'b1) begin
          $display("FAIL o_wait3: got %0b want 1", ioctl_wait); errs++;
        end
      end
      if (i == 3) begin
        vecs++;
        if (dl_error !== 1'b0) begin
          $display("FAIL o_err4: got %0b want 0", dl_error); errs++;
        end
      end
      if (i == 4) begin
        vecs++;
        if (dl_error !== 1'b1) begin
          $display("FAIL o_err5: got %0b want 1", dl_error); errs++;
        end
      end
    end
    ioctl_wr = 1'b0;
    vecs++;
    if (dma_req !== 1'b1 || dma_addr !== 26'h100) begin
      $display("FAIL o_held: got %0b/%0h want 1/100", dma_req, dma_addr);
      errs++;
    end
    for (int r = 0; r < 4; r++) begin
      bit got;
      wait_req(50, got);
      vecs++;
      if (!got || dma_addr !== 26'(32'h100 + r) || dma_data !== 8'h40 + 8'(r)) begin
        $display("FAIL o_req%0d: got %0b/%0h/%0h want 1/%0h/%0h", r, got,
                 dma_addr, dma_data, 32'h100 + r, 8'h40 + 8'(r));
        errs++;
      end
      step();
      dma_ready = 1'b1;
      step();
      dma_ready = 1'b0;
    end
    seen = 1'b0;
    repeat (5) begin
      step();
      if (dma_req) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      $display("FAIL o_dropped: got %0b want 0", seen); errs++;
    end
    ioctl_download = 1'b0;
    wait_done(ok);
    vecs++;
    if (!ok || dl_error !== 1'b1) begin
      $display("FAIL o_sticky: got %0b/%0b want 1/1", ok, dl_error); errs++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    ioctl_index = 8'd3;
    ioctl_download = 1'b1;
    step();
    vecs++;
    if (dl_error !== 1'b0) begin
      $display("FAIL t_clr1: got %0b want 0", dl_error); errs++;
    end
    ioctl_wr = 1'b1;
    ioctl_addr = 27'h55;
    ioctl_dout = 8'h66;
    step();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_req(20, ok);
    n = 0;
    if (ok) begin
      n = 1;
      while (dma_req && n < 5000) begin
        step();
        if (dma_req) n++;
      end
    end
    vecs++;
    if (n !== 4096) begin
      $display("FAIL t_len: got %0d want 4096", n); errs++;
    end
    vecs++;
    if (dl_error !== 1'b1) begin
      $display("FAIL t_err: got %0b want 1", dl_error); errs++;
    end
    wait_done(ok);
    vecs++;
    if (!ok) begin
      $display("FAIL t_done: got no pulse want pulse"); errs++;
    end
    ioctl_index = 8'd4;
    ioctl_download = 1'b1;
    step();
    vecs++;
    if (dl_error !== 1'b0 || file_download !== 1'b1) begin
      $display("FAIL t_clr2: got %0b/%0b want 0/1", dl_error, file_download);
      errs++;
    end
    ioctl_download = 1'b0;
    wait_done(ok);
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    bit seen;
    ioctl_index = 8'd5;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 27'(32'h10 + i);
      ioctl_dout = 8'(i);
      step();
    end
    ioctl_wr = 1'b0;
    wait_req(20, ok);
    vecs++;
    if (!ok) begin
      $display("FAIL r_req: got no request want request"); errs++;
    end
    reset = 1'b1;
    step();
    vecs++;
    if (dma_req !== 1'b0 || ioctl_wait !== 1'b1 || file_download !== 1'b0) begin
      $display("FAIL r_drop: got %0b/%0b/%0b want 0/1/0",
               dma_req, ioctl_wait, file_download);
      errs++;
    end
    ioctl_download = 1'b0;
    step();
    reset = 1'b0;
    step();
    vecs++;
    if (ioctl_wait !== 1'b0) begin
      $display("FAIL r_empty: got %0b want 0", ioctl_wait); errs++;
    end
    seen = 1'b0;
    repeat (4) begin
      step();
      if (dma_req) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      $display("FAIL r_noreq: got %0b want 0", seen); errs++;
    end
  endtask

  initial begin
    reset = 1'b1;
    sdram_ready = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_wr = 1'b0;
    dma_ready = 1'b0;
    test_reset();
    test_file_dl();
    test_bios();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
